// File: rtl/sprom_rr_arbiter.sv
// sprom_rr_arbiter: round-robin arbiter sharing one synchronous single-port ROM among NUM_REQ readers,
// with a latency-matched tag pipeline that steers each returned word back to its requester
module sprom_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = (DEPTH >= 2) ? $clog2(DEPTH) : 1,
  parameter int ROM_LATENCY = 1,
  parameter int ID_WIDTH    = (NUM_REQ >= 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic [NUM_REQ-1:0]            REQ_VALID_I,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR_I,
  output logic [NUM_REQ-1:0]            REQ_READY_O,
  output logic [NUM_REQ-1:0]            RESP_VALID_O,
  output logic [ID_WIDTH-1:0]           RESP_ID_O,
  output logic [DATA_WIDTH-1:0]         RESP_DATA_O,
  output logic [ADDR_WIDTH-1:0]         ROM_RADDR_O,
  input  logic [DATA_WIDTH-1:0]         ROM_RDATA_I
);
  if (ROM_LATENCY != 1 && ROM_LATENCY != 2) begin : g_bad_latency
    $error("ROM_LATENCY must be 1 or 2");
  end
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d, gnt_id, idx;
  logic                   gnt_any;
  logic [ROM_LATENCY-1:0] vld_q, vld_d;
  logic [ID_WIDTH-1:0]    id_q [ROM_LATENCY];
  logic [ID_WIDTH-1:0]    id_d [ROM_LATENCY];
  // scan from the far end back toward PTR so the nearest valid requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
      if (REQ_VALID_I[idx] && !RST_I) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end
  assign REQ_READY_O = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
  assign ROM_RADDR_O = gnt_any ? REQ_ADDR_I[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign ptr_d = gnt_any ? ((gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1)) : ptr_q;
  // ids only advance alongside a valid bit so RESP_ID_O holds between responses
  always_comb begin
    vld_d    = '0;
    vld_d[0] = gnt_any;
    id_d[0]  = gnt_any ? gnt_id : id_q[0];
    for (int s = 1; s < ROM_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = vld_q[s-1] ? id_q[s-1] : id_q[s];
    end
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ptr_q <= '0;
      vld_q <= '0;
      id_q  <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end
  assign RESP_VALID_O = vld_q[ROM_LATENCY-1] ? NUM_REQ'(1) << id_q[ROM_LATENCY-1] : '0;
  assign RESP_ID_O    = id_q[ROM_LATENCY-1];
  assign RESP_DATA_O  = ROM_RDATA_I;
endmodule

// File: tb/tb_sprom_rr_arbiter.sv
// tb_sprom_rr_arbiter: directed bench driving a ROM_LATENCY=1 and a ROM_LATENCY=2 instance side by side
module tb_sprom_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld = '0;
  logic [31:0] addr = '0;
  logic [3:0]  rdy1, rdy2, rv1, rv2;
  logic [1:0]  id1, id2;
  logic [15:0] d1, d2, rd1, rd2, rd2a;
  logic [7:0]  ra1, ra2;
  logic [15:0] tbl [4] = '{16'hA5A5, 16'hA5A1, 16'hA5AD, 16'hA5A9};
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sprom_rr_arbiter #(.ROM_LATENCY(1)) dut1 (
    .CLK_I(clk), .RST_I(rst), .REQ_VALID_I(vld), .REQ_ADDR_I(addr), .REQ_READY_O(rdy1),
    .RESP_VALID_O(rv1), .RESP_ID_O(id1), .RESP_DATA_O(d1), .ROM_RADDR_O(ra1), .ROM_RDATA_I(rd1)
  );
  sprom_rr_arbiter #(.ROM_LATENCY(2)) dut2 (
    .CLK_I(clk), .RST_I(rst), .REQ_VALID_I(vld), .REQ_ADDR_I(addr), .REQ_READY_O(rdy2),
    .RESP_VALID_O(rv2), .RESP_ID_O(id2), .RESP_DATA_O(d2), .ROM_RADDR_O(ra2), .ROM_RDATA_I(rd2)
  );
  // ROM models: ROM[a] = a ^ 16'hA5A5
  always_ff @(posedge clk) begin
    rd1  <= {8'h00, ra1} ^ 16'hA5A5;
    rd2a <= {8'h00, ra2} ^ 16'hA5A5;
    rd2  <= rd2a;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  initial begin
    vld = 4'hF;
    cyc();
    cyc();
    #1;
    check("rst_rdy1", 32'(rdy1), 0);
    check("rst_rdy2", 32'(rdy2), 0);
    check("rst_rv1", 32'(rv1), 0);
    check("rst_rv2", 32'(rv2), 0);
    check("rst_id1", 32'(id1), 0);
    rst = 1'b0;
    vld = '0;
    cyc();
    vld  = 4'b0100;
    addr = 32'h0010_0000;
    #1;
    check("single_rdy1", 32'(rdy1), 32'h4);
    check("single_rdy2", 32'(rdy2), 32'h4);
    check("single_raddr", 32'(ra1), 32'h10);
    cyc();
    vld = '0;
    #1;
    check("single_rv1", 32'(rv1), 32'h4);
    check("single_id1", 32'(id1), 2);
    check("single_d1", 32'(d1), 32'hA5B5);
    check("single_rv2_early", 32'(rv2), 0);
    cyc();
    check("single_rv1_off", 32'(rv1), 0);
    check("single_id1_hold", 32'(id1), 2);
    check("single_rv2", 32'(rv2), 32'h4);
    check("single_id2", 32'(id2), 2);
    check("single_d2", 32'(d2), 32'hA5B5);
    cyc();
    check("single_rv2_off", 32'(rv2), 0);
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    addr = {8'h0C, 8'h08, 8'h04, 8'h00};
    vld  = 4'hF;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("all_rdy", 32'(rdy1), 32'(1 << (j % 4)));
      check("all_raddr", 32'(ra1), 32'(4 * (j % 4)));
      cyc();
      check("all_rv1", 32'(rv1), 32'(1 << (j % 4)));
      check("all_id1", 32'(id1), 32'(j % 4));
      check("all_d1", 32'(d1), 32'(tbl[j % 4]));
      if (j > 0) begin
        check("all_rv2", 32'(rv2), 32'(1 << ((j - 1) % 4)));
        check("all_d2", 32'(d2), 32'(tbl[(j - 1) % 4]));
      end
    end
    vld = '0;
    cyc();
    cyc();
    vld = 4'b1001;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("fair_rdy", 32'(rdy1), (j % 2) ? 32'h8 : 32'h1);
      cyc();
    end
    vld = '0;
    cyc();
    cyc();
    vld = 4'b0010;
    #1;
    check("rstmid_rdy", 32'(rdy2), 32'h2);
    cyc();
    vld = 4'b0001;
    rst = 1'b1;
    #1;
    check("rstmid_forced_rdy1", 32'(rdy1), 0);
    check("rstmid_forced_rdy2", 32'(rdy2), 0);
    cyc();
    check("rstmid_no_pulse", 32'(rv2), 0);
    rst = 1'b0;
    vld = 4'b0101;
    #1;
    check("rstmid_ptr0", 32'(rdy2), 32'h1);
    check("rstmid_quiet", 32'(rv2), 0);
    cyc();
    vld = 4'b0100;
    #1;
    check("rstmid_next", 32'(rdy2), 32'h4);
    check("rstmid_quiet2", 32'(rv2), 0);
    cyc();
    vld = '0;
    check("rstmid_rv_0", 32'(rv2), 32'h1);
    check("rstmid_d_0", 32'(d2), 32'hA5A5);
    cyc();
    check("rstmid_rv_2", 32'(rv2), 32'h4);
    check("rstmid_d_2", 32'(d2), 32'hA5AD);
    cyc();
    vld = 4'b0011;
    #1;
    check("wd_rdy", 32'(rdy1), 32'h1);
    cyc();
    vld = '0;
    #1;
    check("wd_rdy_drop", 32'(rdy1), 0);
    check("wd_rv1", 32'(rv1), 32'h1);
    cyc();
    check("wd_rv1_none", 32'(rv1), 0);
    cyc();
    addr = '1;
    for (int j = 0; j < 10; j++) begin
      #1;
      check("idle_rdy", 32'(rdy1), 0);
      check("idle_raddr", 32'(ra1), 0);
      check("idle_rv1", 32'(rv1), 0);
      check("idle_rv2", 32'(rv2), 0);
      cyc();
    end
    vld = 4'hF;
    #1;
    check("idle_ptr_held", 32'(rdy1), 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprom_rr_arbiter.md
Name: sprom_rr_arbiter

Overview:
- Shares one single-port ROM (synchronous read, 1- or 2-cycle latency) between NUM_REQ independent read requesters.
- Each cycle, one pending request is granted in round-robin order and its address is driven to the ROM.
- A tag pipeline matched to the ROM latency routes the returned word back to the requester that issued it.
- Sits between client blocks (coefficient/table fetchers) and the ROM instance; pipelined, one read accepted per cycle.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 16, ROM word width.
- DEPTH, 256, ROM depth.
- ADDR_WIDTH, (DEPTH >= 2) ? $clog2(DEPTH) : 1, ROM address width.
- ROM_LATENCY, 1, ROM read latency in cycles: 1 = no output register, 2 = output register enabled; other values illegal (elaboration error).
- ID_WIDTH, (NUM_REQ >= 2) ? $clog2(NUM_REQ) : 1, requester index width.

Ports:
- CLK_I  in  1  clock; all logic on rising edge.
- RST_I  in  1  synchronous reset, active-high.
- REQ_VALID_I  in  NUM_REQ  per-requester read request.
- REQ_ADDR_I  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester n occupies bits [n*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_READY_O  out  NUM_REQ  one-hot grant; request n is accepted when REQ_VALID_I[n] && REQ_READY_O[n].
- RESP_VALID_O  out  NUM_REQ  one-hot, registered; data for requester n is valid this cycle.
- RESP_ID_O  out  ID_WIDTH  index of the requester receiving RESP_DATA_O.
- RESP_DATA_O  out  DATA_WIDTH  returned ROM word (ROM_RDATA_I passed through).
- ROM_RADDR_O  out  ADDR_WIDTH  address to the ROM read port.
- ROM_RDATA_I  in  DATA_WIDTH  ROM read data.

Behaviour:
- Reset (RST_I=1 at a clock edge):
  - round-robin pointer PTR <= 0;
  - all tag-pipeline valid bits cleared; RESP_VALID_O = 0; RESP_ID_O = 0;
  - REQ_READY_O forced to 0 while RST_I=1.
  - Reads in flight at reset are discarded; no response is ever issued for them.
- Arbitration (combinational, same cycle):
  - Scan indices PTR, PTR+1, …, wrapping modulo NUM_REQ.
  - The first n with REQ_VALID_I[n]=1 gets REQ_READY_O[n]=1; all other ready bits are 0.
  - No valid request gives REQ_READY_O = 0.
  - REQ_READY_O never depends on requests from other requesters beyond priority; no stall sources exist.
- ROM_RADDR_O = address of the granted requester; 0 when no grant.
- Pointer update: on a grant to n, PTR <= (n+1) mod NUM_REQ; with no grant, PTR holds.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- Tag pipeline: ROM_LATENCY stages of {valid, id}.
  - Stage 0 captures {grant_any, granted id}.
  - Each further stage shifts once per cycle.
  - Final stage drives RESP_VALID_O (decoded one-hot) and RESP_ID_O.
- Response timing: a request accepted at edge k has RESP_VALID_O asserted in the cycle after edge k+ROM_LATENCY.
  - This aligns with ROM_RDATA_I, so RESP_DATA_O = ROM[addr].
  - Throughput is 1 response per cycle; back-to-back grants give back-to-back responses in grant order.
- RESP_ID_O holds its last value when RESP_VALID_O=0.
- RESP_DATA_O is valid only when RESP_VALID_O≠0.
- No response backpressure: consumers sample RESP_DATA_O in the cycle their RESP_VALID_O bit is high.
- Requester behaviour:
  - A requester keeps REQ_VALID_I and its address stable until accepted.
  - It may issue its next request in the cycle after acceptance.
  - Deasserting REQ_VALID_I before acceptance withdraws the request (no response).
- Boundary cases:
  - PTR wrap: NUM_REQ-1 → 0.
  - Single requester always valid: granted every cycle.
  - All valid: grants rotate 0,1,2,…,NUM_REQ-1,0,…
  - A request arriving in the same cycle RST_I deasserts is arbitrated normally on the next edge (PTR=0).

Test Plan:
- Setup: NUM_REQ=4, ROM[a]=a^16'hA5A5.
- Single request, ROM_LATENCY=1: requester 2 requests addr 8'h10 at edge 0 → REQ_READY_O=4'b0100 that cycle; after edge 1, RESP_VALID_O=4'b0100, RESP_ID_O=2, RESP_DATA_O=16'hA5B5. With ROM_LATENCY=2 the same response arrives one cycle later.
- All four requesters valid continuously (addr = 4*n): grants 0,1,2,3,0,… each cycle → RESP_DATA_O sequence A5A5, A5A1, A5AD, A5A9 repeating, one per cycle, IDs matching.
- Fairness: requesters 0 and 3 held valid for 8 cycles → grants alternate 0,3,0,3; neither is starved for more than 1 cycle.
- Reset mid-flight: ROM_LATENCY=2, grant requester 1 at edge k, RST_I=1 at edge k+1 → no RESP_VALID_O pulse; after reset, PTR=0, so requests from 0 and 2 grant 0 first.
- Withdrawal: requester 1 valid for one cycle while requester 0 is granted, then dropped → requester 1 never granted and never responded to; RESP_VALID_O shows only the bit-0 response.
- Idle: no requests for 10 cycles → REQ_READY_O=0, ROM_RADDR_O=0, RESP_VALID_O=0, PTR unchanged.
